srdl2sv_amba3ahblite_bridge: RTL and testbench
==============================================

SRDL2SV_AMBA3AHBLITE_BRIDGE -- requirements
Module: srdl2sv_amba3ahblite_bridge

Interface
REQ-001 Parameters SHALL be: BUS_BITS, default 32, data width (32/64/128); ADDR_BITS, default 32, address width; NO_BYTE_ENABLE, default 0, force all byte enables high; TIMEOUT_CYCLES, default 256, register-side wait limit (>=2).
REQ-002 HCLK  in  1  sole clock, all logic on rising edge.
REQ-003 HRESET  in  1  reset, synchronous and active-high.
REQ-004 HSEL in 1; HREADY in 1, bus-wide ready; HADDR in ADDR_BITS; HWRITE in 1; HSIZE in 3; HTRANS in 2; HPROT in 4, unused; HWDATA in BUS_BITS, data-phase write data.
REQ-005 HREADYOUT out 1; HRESP out 1; HRDATA out BUS_BITS.
REQ-006 b2r_addr out ADDR_BITS, word-aligned; b2r_data out BUS_BITS; b2r_byte_en out BUS_BITS/8; b2r_w_vld out 1; b2r_r_vld out 1.
REQ-007 r2b_data in BUS_BITS; r2b_rdy in 1, access complete; r2b_err in 1, qualified by r2b_rdy.

Function
REQ-008 An address phase SHALL be accepted when HSEL & HREADY & HTRANS in {NONSEQ, SEQ}; HADDR, HSIZE, HWRITE SHALL be registered on acceptance only.
REQ-009 IDLE/BUSY transfers, or HSEL low, SHALL get a zero-wait OKAY data phase with no register-side strobe.
REQ-010 FSM states SHALL be IDLE, TRANS, ERR_0, ERR_1; IDLE->TRANS on a legal accepted transfer; IDLE->ERR_0 on an illegal one.
REQ-011 A transfer SHALL be illegal when HADDR is not a multiple of 2^HSIZE or 2^HSIZE > BUS_BITS/8.
REQ-012 In TRANS: b2r_w_vld = HWRITE_q, b2r_r_vld = !HWRITE_q, held every cycle until r2b_rdy; HREADYOUT = r2b_rdy & !r2b_err; HRESP = 0.
REQ-013 b2r_addr SHALL be HADDR_q with low log2(BUS_BITS/8) bits zeroed; b2r_data SHALL be HWDATA unshifted (AHB lane placement).
REQ-014 b2r_byte_en SHALL be (2^(2^HSIZE_q) - 1) shifted left by HADDR_q mod (BUS_BITS/8); all ones when NO_BYTE_ENABLE=1.
REQ-015 HRDATA SHALL equal r2b_data with bytes outside b2r_byte_en forced to 0 while in TRANS, else 0.
REQ-016 On r2b_rdy & !r2b_err: TRANS->TRANS if a new legal transfer is accepted the same cycle (back-to-back, no bubble), ->ERR_0 if a new illegal one, else ->IDLE.
REQ-017 On r2b_rdy & r2b_err: TRANS->ERR_0.
REQ-018 ERR_0: HREADYOUT=0, HRESP=1, strobes low, ->ERR_1; ERR_1: HREADYOUT=1, HRESP=1, ->IDLE, or ->TRANS/ERR_0 if a new transfer is accepted that cycle.
REQ-019 HRESP SHALL only be driven 1 in ERR_0/ERR_1 (two-cycle ERROR response).

Reset
REQ-020 While HRESET=1 at a rising edge: FSM->IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, b2r_w_vld=0, b2r_r_vld=0, timeout counter=0 from the next cycle.
REQ-021 Reset mid-TRANS SHALL drop the pending strobe without completion; registered address/size need no reset.

Configuration
REQ-022 Macro SRDL2SV_AHB_TIMEOUT_EN SHALL compile in a wait counter: cleared on entering TRANS and on each accepted transfer, incremented each TRANS cycle with r2b_rdy=0.
REQ-023 With the macro, when the counter reaches TIMEOUT_CYCLES-1 with r2b_rdy=0, the next state SHALL be ERR_0 with strobes deasserted; r2b_rdy in that same cycle wins over timeout.
REQ-024 Without the macro, no counter SHALL exist, TIMEOUT_CYCLES SHALL be ignored, TRANS SHALL wait indefinitely.

Verification
REQ-025 BUS_BITS=32: write HADDR=0x10, HSIZE=2, HWDATA=0xA5A5_1234, r2b_rdy=1 -> b2r_w_vld 1 cycle, b2r_addr=0x10, byte_en=4'b1111, OKAY zero-wait.
REQ-026 Read HADDR=0x13, HSIZE=0, r2b_data=0xDEAD_BEEF, r2b_rdy after 3 cycles -> byte_en=4'b1000, 3 HREADYOUT-low cycles, HRDATA=0xDE00_0000.
REQ-027 Write HADDR=0x02, HSIZE=2 -> no strobe, HREADYOUT/HRESP = 0/1 then 1/1, then IDLE.
REQ-028 Back-to-back NONSEQ write 0x0 then read 0x4, r2b_rdy=1 -> one w_vld then one r_vld on consecutive cycles, no IDLE bubble.
REQ-029 Macro on, TIMEOUT_CYCLES=4, r2b_rdy stuck 0 -> 4 strobe cycles, then two-cycle ERROR; macro off -> HREADYOUT stays 0.
REQ-030 HRESET=1 during a stalled read -> next cycle b2r_r_vld=0, HREADYOUT=1, HRESP=0, HRDATA=0.

Source files
------------

// File: rtl/srdl2sv_amba3ahblite_bridge.sv
// AHB-Lite slave bridging single transfers onto a simple register-block strobe interface.
// Optional register-side wait timeout is compiled in with `define SRDL2SV_AHB_TIMEOUT_EN.
module srdl2sv_amba3ahblite_bridge #(
  parameter int unsigned BUS_BITS       = 32,
  parameter int unsigned ADDR_BITS      = 32,
  parameter bit          NO_BYTE_ENABLE = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic                    HREADY,
  input  logic [ADDR_BITS-1:0]    HADDR,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [1:0]              HTRANS,
  input  logic [3:0]              HPROT,
  input  logic [BUS_BITS-1:0]     HWDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [BUS_BITS-1:0]     HRDATA,
  output logic [ADDR_BITS-1:0]    b2r_addr,
  output logic [BUS_BITS-1:0]     b2r_data,
  output logic [BUS_BITS/8-1:0]   b2r_byte_en,
  output logic                    b2r_w_vld,
  output logic                    b2r_r_vld,
  input  logic [BUS_BITS-1:0]     r2b_data,
  input  logic                    r2b_rdy,
  input  logic                    r2b_err
);

  localparam int unsigned BYTES    = BUS_BITS / 8;
  localparam int unsigned OFF_BITS = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, TRANS, ERR_0, ERR_1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  state_t                 xfer_nxt_c;
  logic                   accept_c;
  logic                   illegal_c;
  logic                   timeout_c;
  logic [7:0]             req_bytes_c;
  logic [7:0]             size_q_bytes_c;
  logic [ADDR_BITS-1:0]   haddr_q;
  logic [2:0]             hsize_q;
  logic                   hwrite_q;
  logic [OFF_BITS-1:0]    off_c;
  logic                   unused_ok;

  // Address phase qualification and legality of the incoming transfer
  assign accept_c    = HSEL & HREADY & HTRANS[1];
  assign req_bytes_c = 8'(1) << HSIZE;
  assign illegal_c   = ((HADDR[6:0] & 7'(req_bytes_c - 8'd1)) != 7'd0) ||
                       (req_bytes_c > 8'(BYTES));
  assign xfer_nxt_c  = illegal_c ? ERR_0 : TRANS;

  // Address-phase capture; only meaningful for the transfer in its data phase
  always_ff @(posedge HCLK) begin
    if (accept_c) begin
      haddr_q  <= HADDR;
      hsize_q  <= HSIZE;
      hwrite_q <= HWRITE;
    end
  end

`ifdef SRDL2SV_AHB_TIMEOUT_EN
  localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_BITS-1:0] wait_cnt;

  // Counts unanswered TRANS cycles; restarts with every accepted transfer
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wait_cnt <= '0;
    end else if (accept_c) begin
      wait_cnt <= '0;
    end else if ((state == TRANS) && !r2b_rdy) begin
      wait_cnt <= wait_cnt + CNT_BITS'(1);
    end
  end

  assign timeout_c = (state == TRANS) && !r2b_rdy &&
                     (wait_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and data-phase response
  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    b2r_w_vld = 1'b0;
    b2r_r_vld = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_nxt = xfer_nxt_c;
        end
      end
      TRANS: begin
        b2r_w_vld = hwrite_q;
        b2r_r_vld = !hwrite_q;
        HREADYOUT = r2b_rdy & !r2b_err;
        if (r2b_rdy) begin
          if (r2b_err) begin
            state_nxt = ERR_0;
          end else if (accept_c) begin
            state_nxt = xfer_nxt_c;
          end else begin
            state_nxt = IDLE;
          end
        end else if (timeout_c) begin
          state_nxt = ERR_0;
        end
      end
      ERR_0: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ERR_1;
      end
      ERR_1: begin
        HRESP = 1'b1;
        if (accept_c) begin
          state_nxt = xfer_nxt_c;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign b2r_addr = {haddr_q[ADDR_BITS-1:OFF_BITS], OFF_BITS'(0)};
  assign b2r_data = HWDATA;
  assign off_c    = haddr_q[OFF_BITS-1:0];
  assign size_q_bytes_c = 8'(1) << hsize_q;

  // Byte lanes covered by the transfer inside the bus word
  always_comb begin
    b2r_byte_en = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if ((i >= 32'(off_c)) && (i < 32'(off_c) + 32'(size_q_bytes_c))) begin
        b2r_byte_en[i] = 1'b1;
      end
    end
    if (NO_BYTE_ENABLE) begin
      b2r_byte_en = '1;
    end
  end

  // Read data returned only on the enabled lanes, only while in TRANS
  always_comb begin
    HRDATA = '0;
    if (state == TRANS) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (b2r_byte_en[i]) begin
          HRDATA[i*8 +: 8] = r2b_data[i*8 +: 8];
        end
      end
    end
  end

  // Inputs and parameters with no function in this build
  assign unused_ok = ^{HPROT, HTRANS[0], 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_srdl2sv_amba3ahblite_bridge.sv
// Scoreboard bench for srdl2sv_amba3ahblite_bridge: directed AHB transfers, register-side responder,
// and a negedge monitor that pops expected register accesses and ERROR-response cycles.
module tb_srdl2sv_amba3ahblite_bridge;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] b2r_addr;
  logic [31:0] b2r_data;
  logic [3:0]  b2r_byte_en;
  logic        b2r_w_vld;
  logic        b2r_r_vld;
  logic [31:0] r2b_data;
  logic        r2b_rdy;
  logic        r2b_err;

  srdl2sv_amba3ahblite_bridge #(
    .BUS_BITS(32), .ADDR_BITS(32), .NO_BYTE_ENABLE(1'b0), .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HTRANS(HTRANS), .HPROT(HPROT), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .b2r_addr(b2r_addr), .b2r_data(b2r_data), .b2r_byte_en(b2r_byte_en),
    .b2r_w_vld(b2r_w_vld), .b2r_r_vld(b2r_r_vld),
    .r2b_data(r2b_data), .r2b_rdy(r2b_rdy), .r2b_err(r2b_err)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } reg_exp_t;

  reg_exp_t reg_q[$];
  logic     resp_q[$];
  reg_exp_t e;
  logic     er;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_evt_cyc = 0;
  int prev_evt_cyc = 0;
  int wait_cnt = 0;
  int rdy_delay = 0;
  logic stuck = 1'b0;
  logic err_mode = 1'b0;
  logic [31:0] rd_data = '0;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Single-slave system: bus-wide HREADY is this slave's HREADYOUT
  assign HREADY   = HREADYOUT;
  assign r2b_data = rd_data;
  assign r2b_err  = err_mode;
  assign r2b_rdy  = !stuck && (b2r_w_vld || b2r_r_vld) && (wait_cnt >= rdy_delay);

  always @(posedge HCLK) begin
    cyc      <= cyc + 1;
    wait_cnt <= ((b2r_w_vld || b2r_r_vld) && !r2b_rdy) ? wait_cnt + 1 : 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: register-side completions and ERROR-response cycles
  always @(negedge HCLK) begin
    if (!HRESET) begin
      if ((b2r_w_vld || b2r_r_vld) && r2b_rdy) begin
        prev_evt_cyc = last_evt_cyc;
        last_evt_cyc = cyc;
        chk("strobe_expected", 64'(reg_q.size() != 0), 64'(1));
        if (reg_q.size() != 0) begin
          e = reg_q.pop_front();
          chk("w_vld", 64'(b2r_w_vld), 64'(e.w));
          chk("r_vld", 64'(b2r_r_vld), 64'(!e.w));
          chk("b2r_addr", 64'(b2r_addr), 64'(e.addr));
          chk("byte_en", 64'(b2r_byte_en), 64'(e.be));
          if (e.w) chk("b2r_data", 64'(b2r_data), 64'(e.wdata));
          else if (!e.err) chk("hrdata", 64'(HRDATA), 64'(e.rdata));
          chk("hreadyout_done", 64'(HREADYOUT), 64'(!e.err));
          chk("hresp_okay", 64'(HRESP), 64'(0));
        end
      end
      if (HRESP) begin
        chk("resp_expected", 64'(resp_q.size() != 0), 64'(1));
        if (resp_q.size() != 0) begin
          er = resp_q.pop_front();
          chk("err_hreadyout", 64'(HREADYOUT), 64'(er));
        end
      end
    end
  end

  task automatic addr_phase(input logic w, input logic [31:0] a, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = w; HADDR = a; HSIZE = sz;
  endtask

  task automatic idle_bus();
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  // Waits for HREADYOUT high, counts low cycles, returns #1 after the completing edge
  task automatic wait_ready(output int stalls);
    stalls = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge HCLK);
      if (HREADYOUT) break;
      stalls++;
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic single(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, input int exp_stalls, input string name);
    int s;
    addr_phase(w, a, sz);
    wait_ready(s);
    chk({name, "_accept"}, 64'(s), 64'(0));
    idle_bus();
    HWDATA = wd;
    wait_ready(s);
    chk({name, "_stalls"}, 64'(s), 64'(exp_stalls));
  endtask

  task automatic push_reg(input logic w, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] rd, input logic err);
    reg_exp_t x;
    x.w = w; x.addr = a; x.be = be; x.wdata = wd; x.rdata = rd; x.err = err;
    reg_q.push_back(x);
  endtask

  task automatic push_err();
    resp_q.push_back(1'b0);
    resp_q.push_back(1'b1);
  endtask

  initial begin
    int s;
    logic bad;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HSIZE = '0;
    HTRANS = 2'b00; HPROT = 4'h3; HWDATA = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_hreadyout", 64'(HREADYOUT), 64'(1));
    chk("rst_hresp", 64'(HRESP), 64'(0));
    chk("rst_hrdata", 64'(HRDATA), 64'(0));
    chk("rst_strobes", 64'({b2r_w_vld, b2r_r_vld}), 64'(0));
    @(posedge HCLK); #1;
    HRESET = 1'b0;

    // Word write, zero wait
    rdy_delay = 0;
    push_reg(1'b1, 32'h10, 4'b1111, 32'hA5A5_1234, 32'h0, 1'b0);
    single(1'b1, 32'h10, 3'd2, 32'hA5A5_1234, 0, "wr_word");

    // Byte read at 0x13 with three wait states
    rdy_delay = 3; rd_data = 32'hDEAD_BEEF;
    push_reg(1'b0, 32'h10, 4'b1000, 32'h0, 32'hDE00_0000, 1'b0);
    single(1'b0, 32'h13, 3'd0, 32'h0, 3, "rd_byte");

    // Halfword write to upper lanes, one wait state
    rdy_delay = 1;
    push_reg(1'b1, 32'h14, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0);
    single(1'b1, 32'h16, 3'd1, 32'hBEEF_0000, 1, "wr_half");

    // Misaligned word write: ERROR, no strobe
    push_err();
    single(1'b1, 32'h02, 3'd2, 32'h0, 1, "misalign");

    // Transfer wider than the bus: ERROR
    push_err();
    single(1'b0, 32'h08, 3'd3, 32'h0, 1, "oversize");

    // Register-side error after one wait state
    rdy_delay = 1; err_mode = 1'b1;
    push_reg(1'b1, 32'h20, 4'b1111, 32'h0123_4567, 32'h0, 1'b1);
    push_err();
    single(1'b1, 32'h20, 3'd2, 32'h0123_4567, 3, "reg_err");
    err_mode = 1'b0;

    // Back-to-back write then read with no bubble
    rdy_delay = 0; rd_data = 32'h3344_5566;
    push_reg(1'b1, 32'h0, 4'b1111, 32'h1111_2222, 32'h0, 1'b0);
    push_reg(1'b0, 32'h4, 4'b1111, 32'h0, 32'h3344_5566, 1'b0);
    addr_phase(1'b1, 32'h0, 3'd2);
    wait_ready(s);
    addr_phase(1'b0, 32'h4, 3'd2);
    HWDATA = 32'h1111_2222;
    wait_ready(s);
    chk("b2b_first_stalls", 64'(s), 64'(0));
    idle_bus();
    wait_ready(s);
    chk("b2b_second_stalls", 64'(s), 64'(0));
    chk("b2b_gap", 64'(last_evt_cyc - prev_evt_cyc), 64'(1));

    // IDLE, BUSY and unselected NONSEQ get zero-wait OKAY
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h40;
    @(negedge HCLK);
    chk("idle_okay", 64'({HREADYOUT, HRESP, b2r_w_vld, b2r_r_vld}), 64'(4'b1000));
    @(posedge HCLK); #1;
    HTRANS = 2'b01;
    @(negedge HCLK);
    chk("busy_okay", 64'({HREADYOUT, HRESP, b2r_w_vld, b2r_r_vld}), 64'(4'b1000));
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b10;
    @(negedge HCLK);
    chk("unsel_okay", 64'({HREADYOUT, HRESP, b2r_w_vld, b2r_r_vld}), 64'(4'b1000));
    @(posedge HCLK); #1;
    idle_bus();
    @(negedge HCLK);
    chk("unsel_no_strobe", 64'({b2r_w_vld, b2r_r_vld}), 64'(0));
    @(posedge HCLK); #1;

    // Register side never answers
    stuck = 1'b1; rd_data = 32'hCAFE_F00D;
`ifdef SRDL2SV_AHB_TIMEOUT_EN
    push_err();
    single(1'b0, 32'h08, 3'd2, 32'h0, 5, "timeout");
    addr_phase(1'b0, 32'h08, 3'd2);
    wait_ready(s);
    idle_bus();
    repeat (2) @(negedge HCLK);
`else
    addr_phase(1'b0, 32'h08, 3'd2);
    wait_ready(s);
    idle_bus();
    bad = 1'b0;
    repeat (20) begin
      @(negedge HCLK);
      if (HREADYOUT !== 1'b0 || b2r_r_vld !== 1'b1) bad = 1'b1;
    end
    chk("stall_hold", 64'(bad), 64'(0));
`endif
    chk("stalled_hrdata", 64'(HRDATA), 64'(32'hCAFE_F00D));

    // Reset during the stalled read
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    stuck = 1'b0;
    @(negedge HCLK);
    chk("rst_mid_r_vld", 64'(b2r_r_vld), 64'(0));
    chk("rst_mid_hreadyout", 64'(HREADYOUT), 64'(1));
    chk("rst_mid_hresp", 64'(HRESP), 64'(0));
    chk("rst_mid_hrdata", 64'(HRDATA), 64'(0));
    @(posedge HCLK); #1;

    // Recovery transfer after reset
    rdy_delay = 0;
    push_reg(1'b1, 32'h1C, 4'b1111, 32'h0BAD_CAFE, 32'h0, 1'b0);
    single(1'b1, 32'h1C, 3'd2, 32'h0BAD_CAFE, 0, "post_rst");

    repeat (3) @(posedge HCLK);
    chk("reg_q_drained", 64'(reg_q.size()), 64'(0));
    chk("resp_q_drained", 64'(resp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
